// File: rtl/dhs_obi_mem_resp_if.sv
// OBI single-beat request/response bundle between a core port and a memory responder.
interface dhs_obi_mem_resp_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dhs_obi_mem_resp.sv
// OBI responder with word-addressed on-chip memory and a fixed-latency in-order response pipe.
// Optional random grant-stall injector compiled in with `define DHS_OBI_RESP_STALL_EN.
module dhs_obi_mem_resp #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              MEM_BYTES = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              LATENCY   = 1
) (
  input logic                clk_i,
  input logic                arst_ni,
  dhs_obi_mem_resp_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int WI_W  = (IDX_W > 2) ? IDX_W - 2 : 1;
  localparam int WORDS = MEM_BYTES / 4;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("dhs_obi_mem_resp: LATENCY must be 1..4");
  end
  if (DATA_W != 32) begin : g_bad_width
    $error("dhs_obi_mem_resp: DATA_W must be 32");
  end
  if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_size
    $error("dhs_obi_mem_resp: MEM_BYTES must be a power of two >= 4");
  end

  logic            hit;
  logic            acc;
  logic [WI_W-1:0] idx;

  assign hit = (bus.addr & ~ADDR_W'(MEM_BYTES - 1)) == BASE_ADDR;
  assign acc = bus.req && bus.gnt;

  if (IDX_W > 2) begin : g_idx
    assign idx = bus.addr[IDX_W-1:2];
  end else begin : g_idx_single
    assign idx = '0;
  end

  // Memory has no reset; contents survive a reset pulse.
  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (acc && hit && bus.we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  logic              s0_valid;
  logic              s0_err;
  logic [DATA_W-1:0] s0_data;

  assign s0_valid = acc;
  assign s0_err   = acc && !hit;
  assign s0_data  = (acc && hit && !bus.we) ? mem[idx] : '0;

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [DATA_W-1:0]  pd [LATENCY];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= s0_valid;
      pe[0] <= s0_err;
      pd[0] <= s0_data;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.rvalid = pv[LATENCY-1];
  assign bus.err    = pe[LATENCY-1];
  assign bus.rdata  = pd[LATENCY-1];

`ifdef DHS_OBI_RESP_STALL_EN
  // state    | meaning
  // ST_GRANT | grant follows req; enter stall when req && lfsr[1:0]==3
  // ST_STALL | grant withheld; leave when lfsr[0]==0 or three stall cycles seen
  typedef enum logic {ST_GRANT, ST_STALL} state_t;

  state_t     state, state_nx;
  logic [7:0] lfsr;
  logic [1:0] cnt, cnt_nx;
  logic       stall_exit;

  assign stall_exit = !lfsr[0] || (cnt == 2'd3);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state <= ST_GRANT;
      lfsr  <= 8'hA5;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (bus.req) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // cnt counts stall cycles including the entry cycle, capping the run at three.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_GRANT: begin
        if (bus.req && lfsr[1:0] == 2'b11) begin
          state_nx = ST_STALL;
          cnt_nx   = 2'd1;
        end
      end
      ST_STALL: begin
        if (bus.req) begin
          if (stall_exit) begin
            state_nx = ST_GRANT;
            cnt_nx   = 2'd0;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      default: begin
        state_nx = ST_GRANT;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  always_comb begin
    bus.gnt = 1'b0;
    case (state)
      ST_GRANT: bus.gnt = bus.req && (lfsr[1:0] != 2'b11);
      ST_STALL: bus.gnt = bus.req && stall_exit;
      default:  bus.gnt = 1'b0;
    endcase
  end
`else
  assign bus.gnt = bus.req;
`endif

endmodule

// File: tb/tb_dhs_obi_mem_resp.sv
// Self-checking bench: LATENCY=1 and LATENCY=3 responders driven identically, checked against a
// cycle-indexed response history and a word-array memory model.
module tb_dhs_obi_mem_resp;
  localparam int AW   = 32;
  localparam int HMAX = 2048;

  logic clk_i = 1'b0;
  logic arst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  dhs_obi_mem_resp_if #(.ADDR_W(AW)) if1 ();
  dhs_obi_mem_resp_if #(.ADDR_W(AW)) if3 ();

  dhs_obi_mem_resp #(.LATENCY(1)) u_lat1 (.clk_i(clk_i), .arst_ni(arst_ni), .bus(if1));
  dhs_obi_mem_resp #(.LATENCY(3)) u_lat3 (.clk_i(clk_i), .arst_ni(arst_ni), .bus(if3));

  int errors = 0;
  int checks = 0;

  logic [31:0] mmod [1024];
  bit          hv [HMAX];
  bit          he [HMAX];
  logic [31:0] hd [HMAX];
  int          cyc = 0;
  int          rst_cyc = 0;
  int          v3_cnt = 0;
  int          run = 0;
  int          maxrun = 0;
  int          stalls = 0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] exp_resp(input int k);
    if (k < 0 || k < rst_cyc) return 34'd0;
    return {hv[k], he[k], hd[k]};
  endfunction

  function automatic logic [33:0] obs1();
    return {if1.rvalid, if1.err, if1.rdata};
  endfunction

  function automatic logic [33:0] obs3();
    return {if3.rvalid, if3.err, if3.rdata};
  endfunction

  // One bus cycle: drive after the falling edge, model the acceptance, check after the next rise.
  task automatic step(input bit req, input logic [31:0] addr, input bit we,
                      input logic [3:0] be, input logic [31:0] wd);
    bit acc, hit;
    int idx;
    if1.req = req; if1.addr = addr; if1.we = we; if1.be = be; if1.wdata = wd;
    if3.req = req; if3.addr = addr; if3.we = we; if3.be = be; if3.wdata = wd;
    #1;
`ifdef DHS_OBI_RESP_STALL_EN
    chk("gnt_match", {33'd0, if3.gnt}, {33'd0, if1.gnt});
    chk("gnt_needs_req", {33'd0, if1.gnt && !req}, 34'd0);
`else
    chk("gnt1_eq_req", {33'd0, if1.gnt}, {33'd0, req});
    chk("gnt3_eq_req", {33'd0, if3.gnt}, {33'd0, req});
`endif
    if (req && !if1.gnt) begin
      run++;
      stalls++;
      if (run > maxrun) maxrun = run;
    end else if (req) begin
      run = 0;
    end
    acc = req && (if1.gnt === 1'b1);
    hit = (addr[31:12] == 20'd0);
    idx = int'(addr[11:2]);
    if (cyc >= HMAX) begin
      $display("FAIL history_overflow cycle=%0d limit=%0d", cyc, HMAX);
      $fatal(1);
    end
    hv[cyc] = acc;
    he[cyc] = acc && !hit;
    hd[cyc] = (acc && hit && !we) ? mmod[idx] : 32'd0;
    if (acc && hit && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mmod[idx][8*b +: 8] = wd[8*b +: 8];
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rsp_lat1", obs1(), exp_resp(cyc));
    chk("rsp_lat3", obs3(), exp_resp(cyc - 2));
    if (if3.rvalid) v3_cnt++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 4'h0, $urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; anything in flight is dropped.
  task automatic do_reset();
    #2 arst_ni = 1'b0;
    #1;
    chk("rst_out_lat1", obs1(), 34'd0);
    chk("rst_out_lat3", obs3(), 34'd0);
    if1.req = 1'b0;
    if3.req = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
    rst_cyc = cyc;
  endtask

  initial begin
    logic [31:0] w0, keep;
    logic [31:0] ra;
    bit          rq, rw;

    if1.req = 0; if1.addr = 0; if1.we = 0; if1.be = 0; if1.wdata = 0;
    if3.req = 0; if3.addr = 0; if3.we = 0; if3.be = 0; if3.wdata = 0;
    for (int i = 0; i < 1024; i++) mmod[i] = 32'd0;

    #1 arst_ni = 1'b0;
    #1;
    chk("init_rst_lat1", obs1(), 34'd0);
    chk("init_rst_lat3", obs3(), 34'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;

    for (int i = 0; i < 64; i++) step(1'b1, 32'(i * 4), 1'b1, 4'hF, $urandom);
    idle(2);

    step(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    chk("write_rsp_zero", obs1(), {1'b1, 1'b0, 32'd0});
    step(1'b1, 32'h10, 1'b0, 4'hF, 32'd0);
    chk("raw_deadbeef", obs1(), {1'b1, 1'b0, 32'hDEADBEEF});

    step(1'b1, 32'h20, 1'b1, 4'hF, 32'h11223344);
    step(1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
    step(1'b1, 32'h22, 1'b0, 4'h0, 32'd0);
    chk("byte_enable", obs1(), {1'b1, 1'b0, 32'h11BB33DD});

    w0 = mmod[0];
    step(1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'd0);
    chk("miss_read", obs1(), {1'b1, 1'b1, 32'd0});
    step(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF);
    chk("miss_write", obs1(), {1'b1, 1'b1, 32'd0});
    step(1'b1, 32'h0, 1'b0, 4'hF, 32'd0);
    chk("miss_no_modify", obs1(), {1'b1, 1'b0, w0});

    idle(3);
    v3_cnt = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b0, 4'hF, 32'd0);
    idle(4);
    chk("burst_pulses", 34'(v3_cnt), 34'd8);

    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(3) != 0);
      rw = $urandom_range(1) == 1;
      if ($urandom_range(9) == 0) ra = 32'h0000_1000 | $urandom;
      else ra = 32'($urandom_range(255));
      step(rq, ra, rw, 4'($urandom_range(15)), $urandom);
    end

    keep = $urandom;
    step(1'b1, 32'h40, 1'b1, 4'hF, keep);
    step(1'b1, 32'h44, 1'b0, 4'hF, 32'd0);
    step(1'b1, 32'h48, 1'b0, 4'hF, 32'd0);
    do_reset();
    v3_cnt = 0;
    idle(4);
    chk("no_resp_after_rst", 34'(v3_cnt), 34'd0);
    step(1'b1, 32'h40, 1'b0, 4'hF, 32'd0);
    chk("write_persists", obs1(), {1'b1, 1'b0, keep});

`ifdef DHS_OBI_RESP_STALL_EN
    run = 0; maxrun = 0; stalls = 0;
    for (int i = 0; i < 200; i++)
      step(1'b1, 32'($urandom_range(255)), $urandom_range(1) == 1, 4'hF, $urandom);
    chk("stall_max_run", {33'd0, maxrun <= 3}, 34'd1);
    chk("stall_seen", {33'd0, stalls > 0}, 34'd1);
    idle(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d limit=200000ns", cyc);
    $fatal(1);
  end
endmodule
